// File: rtl/id_dispatch_queue_pkg.sv
// Shared field widths, bundle layout and pack/unpack helpers for the ID->EX handoff.
package id_dispatch_queue_pkg;

  // Decoded field widths
  localparam int OPCODE_W = 7;
  localparam int FUNCT3_W = 3;
  localparam int FUNCT7_W = 7;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 32;
  localparam int LWSW_W   = 2;
  localparam int CTRL_W   = 4;

  localparam int BUNDLE_W = OPCODE_W + FUNCT3_W + FUNCT7_W + 3 * REG_W + IMM_W + LWSW_W + CTRL_W;

  // Bit offsets inside the packed bundle vector, ctrl in the LSBs, opcode on top
  localparam int CTRL_LSB   = 0;
  localparam int LWSW_LSB   = CTRL_LSB + CTRL_W;
  localparam int IMM_LSB    = LWSW_LSB + LWSW_W;
  localparam int RD_LSB     = IMM_LSB + IMM_W;
  localparam int RS2_LSB    = RD_LSB + REG_W;
  localparam int RS1_LSB    = RS2_LSB + REG_W;
  localparam int FUNCT7_LSB = RS1_LSB + REG_W;
  localparam int FUNCT3_LSB = FUNCT7_LSB + FUNCT7_W;
  localparam int OPCODE_LSB = FUNCT3_LSB + FUNCT3_W;

  // Positions of the individual control bits within ctrl
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [REG_W-1:0]    rd;
    logic [IMM_W-1:0]    imm;
    logic [LWSW_W-1:0]   lwsw;
    logic [CTRL_W-1:0]   ctrl;
  } bundle_t;

  function automatic logic [BUNDLE_W-1:0] pack_bundle(input bundle_t b);
    logic [BUNDLE_W-1:0] v;
    v = '0;
    v[OPCODE_LSB +: OPCODE_W] = b.opcode;
    v[FUNCT3_LSB +: FUNCT3_W] = b.funct3;
    v[FUNCT7_LSB +: FUNCT7_W] = b.funct7;
    v[RS1_LSB    +: REG_W]    = b.rs1;
    v[RS2_LSB    +: REG_W]    = b.rs2;
    v[RD_LSB     +: REG_W]    = b.rd;
    v[IMM_LSB    +: IMM_W]    = b.imm;
    v[LWSW_LSB   +: LWSW_W]   = b.lwsw;
    v[CTRL_LSB   +: CTRL_W]   = b.ctrl;
    return v;
  endfunction

  function automatic bundle_t unpack_bundle(input logic [BUNDLE_W-1:0] v);
    bundle_t b;
    b.opcode = v[OPCODE_LSB +: OPCODE_W];
    b.funct3 = v[FUNCT3_LSB +: FUNCT3_W];
    b.funct7 = v[FUNCT7_LSB +: FUNCT7_W];
    b.rs1    = v[RS1_LSB    +: REG_W];
    b.rs2    = v[RS2_LSB    +: REG_W];
    b.rd     = v[RD_LSB     +: REG_W];
    b.imm    = v[IMM_LSB    +: IMM_W];
    b.lwsw   = v[LWSW_LSB   +: LWSW_W];
    b.ctrl   = v[CTRL_LSB   +: CTRL_W];
    return b;
  endfunction

endpackage

// File: rtl/id_dispatch_queue_if.sv
// ID->issue handoff bundle: enqueue side from ID, dequeue side to issue, plus flush and occupancy.
interface id_dispatch_queue_if
  import id_dispatch_queue_pkg::*;
#(
  parameter int PTR_W = 2
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [OPCODE_W-1:0] opcode_in;
  logic [FUNCT3_W-1:0] funct3_in;
  logic [FUNCT7_W-1:0] funct7_in;
  logic [REG_W-1:0]    srcReg1_in;
  logic [REG_W-1:0]    srcReg2_in;
  logic [REG_W-1:0]    destReg_in;
  logic [IMM_W-1:0]    imm_in;
  logic [LWSW_W-1:0]   lwSw_in;
  logic [CTRL_W-1:0]   ctrl_in;

  logic                out_valid;
  logic                out_ready;
  logic [OPCODE_W-1:0] opcode_out;
  logic [FUNCT3_W-1:0] funct3_out;
  logic [FUNCT7_W-1:0] funct7_out;
  logic [REG_W-1:0]    srcReg1_out;
  logic [REG_W-1:0]    srcReg2_out;
  logic [REG_W-1:0]    destReg_out;
  logic [IMM_W-1:0]    imm_out;
  logic [LWSW_W-1:0]   lwSw_out;
  logic [CTRL_W-1:0]   ctrl_out;

  logic [PTR_W:0]      count;

  // Pipeline side: ID producer, issue consumer and flush source
  modport master (
    output flush, in_valid, opcode_in, funct3_in, funct7_in, srcReg1_in, srcReg2_in,
           destReg_in, imm_in, lwSw_in, ctrl_in, out_ready,
    input  in_ready, out_valid, opcode_out, funct3_out, funct7_out, srcReg1_out,
           srcReg2_out, destReg_out, imm_out, lwSw_out, ctrl_out, count
  );

  // Queue side
  modport slave (
    input  flush, in_valid, opcode_in, funct3_in, funct7_in, srcReg1_in, srcReg2_in,
           destReg_in, imm_in, lwSw_in, ctrl_in, out_ready,
    output in_ready, out_valid, opcode_out, funct3_out, funct7_out, srcReg1_out,
           srcReg2_out, destReg_out, imm_out, lwSw_out, ctrl_out, count
  );
endinterface

// File: rtl/id_dispatch_queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, async clear.
module id_dispatch_queue_mem
  import id_dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = BUNDLE_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next-state of the array: only the addressed entry changes on a write
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage register, cleared to zero on reset so the head reads as all-zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/id_dispatch_queue.sv
// In-order FIFO between ID and issue. Valid/ready on both sides, no bypass, synchronous flush.
module id_dispatch_queue
  import id_dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  id_dispatch_queue_if.slave   bus
);

  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      count_q,  count_d;

  logic                in_ready;
  logic                out_valid;
  logic                push;
  logic                pop;
  logic                wr_en;
  logic [BUNDLE_W-1:0] wr_bundle;
  logic [BUNDLE_W-1:0] rd_bundle;
  bundle_t             in_b;
  bundle_t             head_b;

  // Handshake flags derive from registered occupancy only
  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    out_valid = (count_q != '0);
    push      = bus.in_valid & in_ready;
    pop       = out_valid & bus.out_ready;
    // A bundle arriving in a flush cycle is discarded, so it must not land in storage
    wr_en     = push & ~bus.flush;
  end

  // Pack the incoming decoded fields into one storage word
  always_comb begin
    in_b.opcode = bus.opcode_in;
    in_b.funct3 = bus.funct3_in;
    in_b.funct7 = bus.funct7_in;
    in_b.rs1    = bus.srcReg1_in;
    in_b.rs2    = bus.srcReg2_in;
    in_b.rd     = bus.destReg_in;
    in_b.imm    = bus.imm_in;
    in_b.lwsw   = bus.lwSw_in;
    in_b.ctrl   = bus.ctrl_in;
    wr_bundle   = pack_bundle(in_b);
  end

  // Pointer and occupancy next-state; flush dominates any push/pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  id_dispatch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (BUNDLE_W)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_bundle),
    .raddr (rd_ptr_q),
    .rdata (rd_bundle)
  );

  // Unpack the head entry onto the issue-side fields
  always_comb begin
    head_b          = unpack_bundle(rd_bundle);
    bus.opcode_out  = head_b.opcode;
    bus.funct3_out  = head_b.funct3;
    bus.funct7_out  = head_b.funct7;
    bus.srcReg1_out = head_b.rs1;
    bus.srcReg2_out = head_b.rs2;
    bus.destReg_out = head_b.rd;
    bus.imm_out     = head_b.imm;
    bus.lwSw_out    = head_b.lwsw;
    bus.ctrl_out    = head_b.ctrl;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_id_dispatch_queue.sv
// Self-checking bench for id_dispatch_queue: directed table, corner sequences, random vs queue model.
module tb_id_dispatch_queue;
  import id_dispatch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk;
  logic rstn;
  int   pass_cnt;
  int   total_cnt;

  bundle_t model_q[$];

  id_dispatch_queue_if #(.PTR_W(PTR_W)) bus ();

  id_dispatch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] imm;
    int          exp_count;
    logic        exp_out_valid;
    logic        exp_in_ready;
    logic        chk_imm;
    logic [31:0] exp_imm;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic bundle_t mk(input logic [31:0] imm);
    bundle_t b;
    b.opcode = imm[6:0] ^ 7'h33;
    b.funct3 = imm[2:0];
    b.funct7 = imm[8:2];
    b.rs1    = imm[4:0];
    b.rs2    = imm[4:0] ^ 5'h1f;
    b.rd     = imm[5:1];
    b.imm    = imm;
    b.lwsw   = imm[1:0];
    b.ctrl   = imm[3:0] ^ 4'ha;
    return b;
  endfunction

  function automatic bundle_t rnd_bundle();
    bundle_t b;
    b.opcode = 7'($urandom);
    b.funct3 = 3'($urandom);
    b.funct7 = 7'($urandom);
    b.rs1    = 5'($urandom);
    b.rs2    = 5'($urandom);
    b.rd     = 5'($urandom);
    b.imm    = $urandom;
    b.lwsw   = 2'($urandom);
    b.ctrl   = 4'($urandom);
    return b;
  endfunction

  task automatic drive(input logic fl, input logic iv, input logic ordy, input bundle_t b);
    bus.flush      = fl;
    bus.in_valid   = iv;
    bus.out_ready  = ordy;
    bus.opcode_in  = b.opcode;
    bus.funct3_in  = b.funct3;
    bus.funct7_in  = b.funct7;
    bus.srcReg1_in = b.rs1;
    bus.srcReg2_in = b.rs2;
    bus.destReg_in = b.rd;
    bus.imm_in     = b.imm;
    bus.lwSw_in    = b.lwsw;
    bus.ctrl_in    = b.ctrl;
  endtask

  // Queue model: flush empties, otherwise pop if non-empty and ready, push if not full and valid
  task automatic model_step(input logic fl, input logic iv, input logic ordy, input bundle_t b);
    int  n;
    n = model_q.size();
    if (fl) begin
      model_q.delete();
    end else begin
      if (n != 0 && ordy) void'(model_q.pop_front());
      if (n != DEPTH && iv) model_q.push_back(b);
    end
  endtask

  task automatic cmp_model(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".count"},     32'(bus.count),     32'(n));
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(n != DEPTH));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(n != 0));
    if (n != 0) begin
      chk({tag, ".opcode"}, 32'(bus.opcode_out),  32'(model_q[0].opcode));
      chk({tag, ".funct3"}, 32'(bus.funct3_out),  32'(model_q[0].funct3));
      chk({tag, ".funct7"}, 32'(bus.funct7_out),  32'(model_q[0].funct7));
      chk({tag, ".rs1"},    32'(bus.srcReg1_out), 32'(model_q[0].rs1));
      chk({tag, ".rs2"},    32'(bus.srcReg2_out), 32'(model_q[0].rs2));
      chk({tag, ".rd"},     32'(bus.destReg_out), 32'(model_q[0].rd));
      chk({tag, ".imm"},    bus.imm_out,          model_q[0].imm);
      chk({tag, ".lwsw"},   32'(bus.lwSw_out),    32'(model_q[0].lwsw));
      chk({tag, ".ctrl"},   32'(bus.ctrl_out),    32'(model_q[0].ctrl));
    end
  endtask

  // One clock: inputs already mid-cycle, edge, model update, sample 1ns later
  task automatic tick(input string tag, input logic fl, input logic iv, input logic ordy,
                      input bundle_t b);
    drive(fl, iv, ordy, b);
    @(posedge clk);
    model_step(fl, iv, ordy, b);
    #1;
    cmp_model(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".count"},     32'(bus.count),     32'd0);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, ".imm_out"},   bus.imm_out,        32'd0);
    chk({tag, ".ctrl_out"},  32'(bus.ctrl_out),  32'd0);
  endtask

  initial begin
    bundle_t b;
    pass_cnt  = 0;
    total_cnt = 0;

    // Fill / full / full+pop / flush / post-flush table: expectations after each edge
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'd1,    1, 1'b1, 1'b1, 1'b1, 32'd1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'd2,    2, 1'b1, 1'b1, 1'b1, 32'd1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'd3,    3, 1'b1, 1'b1, 1'b1, 32'd1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'd4,    4, 1'b1, 1'b0, 1'b1, 32'd1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'd5,    4, 1'b1, 1'b0, 1'b1, 32'd1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'd5,    3, 1'b1, 1'b1, 1'b1, 32'd2};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'd5,    4, 1'b1, 1'b0, 1'b1, 32'd2};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'd6,    0, 1'b0, 1'b1, 1'b0, 32'd0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0A5,  1, 1'b1, 1'b1, 1'b1, 32'h0A5};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 32'd0,    0, 1'b0, 1'b1, 1'b0, 32'd0};

    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, mk(32'd0));
    #1;
    chk_reset_outputs("rst_in");
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick("rst_rel", 1'b0, 1'b0, 1'b0, mk(32'd0));
    chk_reset_outputs("rst_first");

    for (int i = 0; i < 10; i++) begin
      tick($sformatf("vec%0d", i), vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready,
           mk(vecs[i].imm));
      chk($sformatf("vec%0d.count", i),     32'(bus.count),     32'(vecs[i].exp_count));
      chk($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_out_valid));
      chk($sformatf("vec%0d.in_ready", i),  32'(bus.in_ready),  32'(vecs[i].exp_in_ready));
      if (vecs[i].chk_imm) chk($sformatf("vec%0d.imm", i), bus.imm_out, vecs[i].exp_imm);
    end

    // Steady stream: one push and one pop per cycle, occupancy held at 1
    for (int k = 0; k < 20; k++) begin
      tick($sformatf("stream%0d", k), 1'b0, 1'b1, 1'b1, mk(32'(k)));
      chk($sformatf("stream%0d.count", k), 32'(bus.count), 32'd1);
      chk($sformatf("stream%0d.imm", k),   bus.imm_out,    32'(k));
    end
    tick("stream_drain", 1'b0, 1'b0, 1'b1, mk(32'd0));
    chk("stream_drain.count", 32'(bus.count), 32'd0);

    // Field integrity across all bundle fields
    b.opcode = 7'h03; b.funct3 = 3'd2; b.funct7 = 7'h20; b.rs1 = 5'd7; b.rs2 = 5'd9;
    b.rd = 5'd31; b.imm = 32'hFFFFF800; b.lwsw = 2'd2; b.ctrl = 4'b1101;
    tick("field_push", 1'b0, 1'b1, 1'b0, b);
    chk("field.opcode", 32'(bus.opcode_out),  32'h03);
    chk("field.funct3", 32'(bus.funct3_out),  32'd2);
    chk("field.funct7", 32'(bus.funct7_out),  32'h20);
    chk("field.rs1",    32'(bus.srcReg1_out), 32'd7);
    chk("field.rs2",    32'(bus.srcReg2_out), 32'd9);
    chk("field.rd",     32'(bus.destReg_out), 32'd31);
    chk("field.imm",    bus.imm_out,          32'hFFFFF800);
    chk("field.lwsw",   32'(bus.lwSw_out),    32'd2);
    chk("field.ctrl",   32'(bus.ctrl_out),    32'b1101);
    tick("field_pop", 1'b0, 1'b0, 1'b1, mk(32'd0));

    // Asynchronous reset with three entries queued
    for (int k = 0; k < 3; k++) tick($sformatf("prerst%0d", k), 1'b0, 1'b1, 1'b0, mk(32'(100 + k)));
    chk("prerst.count", 32'(bus.count), 32'd3);
    drive(1'b0, 1'b0, 1'b0, mk(32'd0));
    rstn = 1'b0;
    #1;
    model_q.delete();
    chk_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_mid_hold");
    rstn = 1'b1;
    tick("rst_mid_rel", 1'b0, 1'b1, 1'b0, mk(32'h77));
    chk("rst_mid_rel.imm", bus.imm_out, 32'h77);

    // Randomized traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      tick($sformatf("rnd%0d", k), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), rnd_bundle());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
